// File: rtl/phase_seq.sv
// -----------------------------------------------------------------------------
// phase_seq -- five-phase instruction sequencer for the 16-bit SIMPLE core.
//
// Walks each instruction through P1 fetch, P2 decode, P3 execute,
// P4 memory/IO and P5 writeback. It emits one-hot phase strobes and the write
// enables that gate the IR, PC, register file and memory. It stalls in P4 on
// memory/IO handshakes, stops on the decoder's halt, and counts retired
// instructions.
//
// Optional build macro: PHASE_SEQ_TIMEOUT_EN
//   defined   : a wait counter plus an ERR state. A wait state that sees no
//               ack for WAIT_TIMEOUT consecutive cycles moves to ERR, which is
//               sticky until rst.
//   undefined : no counter and no ERR state. Wait states hold indefinitely
//               and timeout_err is constant 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset (to IDLE, counters cleared)
//   start        run request, sampled in IDLE and HALT
//   stop         stop request, sampled in P5 only
//   halt_n       active-low halt from the decoder, sampled in P5
//   mem_req      instruction accesses data memory, sampled in P4
//   mem_ack      data memory done
//   io_req       instruction is IN/OUT, sampled in P4
//   io_ack       IO device done
//   phase[4:0]   one-hot phase (bit0 = P1 .. bit4 = P5), 0 outside P1-P5
//   ir_we        instruction register load (P1)
//   pc_we        PC update (P5)
//   rf_we_en     register-file write gate (P5)
//   mem_en       memory access window (P1, P4, WAIT_MEM)
//   stall        high in WAIT_MEM or WAIT_IO
//   running      high in P1-P5 and in the wait states
//   halted       high in HALT
//   timeout_err  high in ERR
//   retired      retired-instruction count, saturating
//
// Handshake: a request is a level qualified by P4 only. If mem_req is high,
// the instruction waits for mem_ack and io_req is ignored. Otherwise, if
// io_req is high, it waits for io_ack. An ack that is already high in P4
// completes the access without a wait cycle. In a wait state only the
// matching ack is looked at.
//
// All outputs are decoded from the registered state only, so no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module phase_seq #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             halt_n,
   input  logic             mem_req,
   input  logic             mem_ack,
   input  logic             io_req,
   input  logic             io_ack,
   output logic [4:0]       phase,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we_en,
   output logic             mem_en,
   output logic             stall,
   output logic             running,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] retired
);

   // A zero timeout would make every wait state an immediate error.
   if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
      $error("phase_seq: WAIT_TIMEOUT must be at least 1");
   end

   typedef enum logic [3:0] {
      S_IDLE,
      S_P1,
      S_P2,
      S_P3,
      S_P4,
      S_WAIT_MEM,
      S_WAIT_IO,
      S_P5,
      S_HALT
`ifdef PHASE_SEQ_TIMEOUT_EN
      , S_ERR
`endif
   } state_t;

   state_t state;
   state_t state_nx;

`ifdef PHASE_SEQ_TIMEOUT_EN
   localparam int WAIT_CNT_W = $clog2(WAIT_TIMEOUT + 1);

   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  wait_expired;

   // wait_cnt is 0 in the first wait cycle. So the last tolerated cycle is
   // the one where it holds WAIT_TIMEOUT-1.
   assign wait_expired = (wait_cnt == WAIT_CNT_W'(WAIT_TIMEOUT - 1));

   // The counter is held at zero outside the wait states. That makes it
   // clear on entry to either wait state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT_MEM || state == S_WAIT_IO) begin
         wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_P1;
         end
         S_P1: state_nx = S_P2;
         S_P2: state_nx = S_P3;
         S_P3: state_nx = S_P4;
         S_P4: begin
            // Memory has priority. io_req is ignored whenever mem_req is set.
            if (mem_req) begin
               state_nx = mem_ack ? S_P5 : S_WAIT_MEM;
            end else if (io_req) begin
               state_nx = io_ack ? S_P5 : S_WAIT_IO;
            end else begin
               state_nx = S_P5;
            end
         end
         S_WAIT_MEM: begin
            // An ack in the same cycle as the timeout still completes.
            if (mem_ack) begin
               state_nx = S_P5;
            end
`ifdef PHASE_SEQ_TIMEOUT_EN
            else if (wait_expired) begin
               state_nx = S_ERR;
            end
`endif
         end
         S_WAIT_IO: begin
            if (io_ack) begin
               state_nx = S_P5;
            end
`ifdef PHASE_SEQ_TIMEOUT_EN
            else if (wait_expired) begin
               state_nx = S_ERR;
            end
`endif
         end
         S_P5: begin
            if (!halt_n) begin
               state_nx = S_HALT;
            end else if (stop) begin
               state_nx = S_IDLE;
            end else begin
               state_nx = S_P1;
            end
         end
         S_HALT: begin
            // The PC was already advanced in P5, so restart resumes at the
            // next instruction.
            if (start) state_nx = S_P1;
         end
`ifdef PHASE_SEQ_TIMEOUT_EN
         S_ERR: state_nx = S_ERR;
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Moore output decode
   always_comb begin
      phase       = 5'b00000;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      rf_we_en    = 1'b0;
      mem_en      = 1'b0;
      stall       = 1'b0;
      running     = 1'b0;
      halted      = 1'b0;
      timeout_err = 1'b0;
      case (state)
         S_P1: begin
            phase   = 5'b00001;
            ir_we   = 1'b1;
            mem_en  = 1'b1;
            running = 1'b1;
         end
         S_P2: begin
            phase   = 5'b00010;
            running = 1'b1;
         end
         S_P3: begin
            phase   = 5'b00100;
            running = 1'b1;
         end
         S_P4: begin
            phase   = 5'b01000;
            mem_en  = 1'b1;
            running = 1'b1;
         end
         S_WAIT_MEM: begin
            phase   = 5'b01000;
            mem_en  = 1'b1;
            stall   = 1'b1;
            running = 1'b1;
         end
         S_WAIT_IO: begin
            phase   = 5'b01000;
            stall   = 1'b1;
            running = 1'b1;
         end
         S_P5: begin
            phase    = 5'b10000;
            pc_we    = 1'b1;
            rf_we_en = 1'b1;
            running  = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
`ifdef PHASE_SEQ_TIMEOUT_EN
         S_ERR: begin
            timeout_err = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   // The retired counter advances at the end of each P5 and sticks at
   // all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= '0;
      end else if (state == S_P5 && retired != {CNT_W{1'b1}}) begin
         retired <= retired + CNT_W'(1);
      end
   end

endmodule
